// File: rtl/toy_store_buffer_pkg.sv
// Shared types and sizes for the store buffer: the store-unit payload,
// the buffer entry wrapper and the widths both sides agree on.
package toy_store_buffer_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int STRB_WIDTH    = 4;
  localparam int LSID_WIDTH    = 4;
  localparam int INST_ID_WIDTH = 6;
  localparam int SB_DEPTH      = 8;

  // Store request as produced by toy_stu; data and strb are still unshifted.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [STRB_WIDTH-1:0]    strb;
    logic [31:0]              inst_pc;
    logic [INST_ID_WIDTH-1:0] inst_id;
    logic [LSID_WIDTH-1:0]    lsid;
    logic                     c_ext;
  } stu_pkg;

  typedef struct packed {
    stu_pkg pld;
  } sb_entry_t;

endpackage

// File: rtl/toy_sb_align.sv
// Byte-lane alignment of a store: word address plus data and strobe moved
// onto the lanes selected by addr[1:0]. Used for drain and overlap checks.
module toy_sb_align
  import toy_store_buffer_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [STRB_WIDTH-1:0] strb,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic [DATA_WIDTH-1:0] lane_data,
  output logic [STRB_WIDTH-1:0] lane_strb
);

  logic [1:0] byte_ofs;

  assign byte_ofs  = addr[1:0];
  assign word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};
  // Bytes shifted past lane 3 are discarded; misaligned stores trap upstream.
  assign lane_data = data << {byte_ofs, 3'b000};
  assign lane_strb = strb << byte_ofs;

endmodule

// File: rtl/toy_store_buffer.sv
// Speculative store buffer: stores are queued, committed in order by the
// retire stage, drained to memory in order, and searched for load overlap.
module toy_store_buffer
  import toy_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_store_vld,
  input  stu_pkg                s_store_pld,
  output logic                  s_store_rdy,
  input  logic                  commit_vld,
  input  logic                  flush,
  output logic                  m_mem_req_vld,
  input  logic                  m_mem_req_rdy,
  output logic [ADDR_WIDTH-1:0] m_mem_req_addr,
  output logic [DATA_WIDTH-1:0] m_mem_req_data,
  output logic [STRB_WIDTH-1:0] m_mem_req_strb,
  output logic [LSID_WIDTH-1:0] m_mem_req_lsid,
  input  logic [ADDR_WIDTH-1:0] ld_chk_addr,
  input  logic [STRB_WIDTH-1:0] ld_chk_strb,
  output logic                  ld_chk_hit,
  output logic                  sb_empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Pointers carry one wrap bit above the index so full and empty differ.
  logic [PTR_W:0]   wr_ptr, cmt_ptr, rd_ptr;
  logic [PTR_W:0]   wr_ptr_nxt, cmt_ptr_nxt, rd_ptr_nxt;
  logic [PTR_W:0]   occ_cnt;
  logic [PTR_W-1:0] rd_idx;
  logic             full, wr_en, cmt_en, drain_en;

  sb_entry_t             entries   [DEPTH];
  logic [ADDR_WIDTH-1:0] lane_addr [DEPTH];
  logic [DATA_WIDTH-1:0] lane_data [DEPTH];
  logic [STRB_WIDTH-1:0] lane_strb [DEPTH];
  logic [DEPTH-1:0]      occupied;
  logic [DEPTH-1:0]      overlap;

  assign occ_cnt  = wr_ptr - rd_ptr;
  assign full     = (occ_cnt == FULL_CNT);
  assign sb_empty = (rd_ptr == wr_ptr);
  assign rd_idx   = rd_ptr[PTR_W-1:0];

  assign s_store_rdy   = ~full;
  assign wr_en         = s_store_vld & ~full & ~flush;
  assign cmt_en        = commit_vld & (cmt_ptr != wr_ptr);
  assign m_mem_req_vld = (rd_ptr != cmt_ptr);
  assign drain_en      = m_mem_req_vld & m_mem_req_rdy;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cmt_ptr_nxt = cmt_ptr + {{PTR_W{1'b0}}, cmt_en};
    rd_ptr_nxt  = rd_ptr  + {{PTR_W{1'b0}}, drain_en};
    wr_ptr_nxt  = wr_ptr  + {{PTR_W{1'b0}}, wr_en};
    // Flush rewinds allocation to the commit boundary, including this cycle's commit.
    if (flush) begin
      wr_ptr_nxt = cmt_ptr_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all pointers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      cmt_ptr <= cmt_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read once the pointers say it is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entries[wr_ptr[PTR_W-1:0]].pld <= s_store_pld;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] slot_ofs;

    toy_sb_align u_align (
      .addr      (entries[i].pld.addr),
      .data      (entries[i].pld.data),
      .strb      (entries[i].pld.strb),
      .word_addr (lane_addr[i]),
      .lane_data (lane_data[i]),
      .lane_strb (lane_strb[i])
    );

    // Slot is live when its distance from the drain head is below the occupancy.
    assign slot_ofs    = PTR_W'(i) - rd_idx;
    assign occupied[i] = ({1'b0, slot_ofs} < occ_cnt);
    assign overlap[i]  = occupied[i]
                       & (lane_addr[i][ADDR_WIDTH-1:2] == ld_chk_addr[ADDR_WIDTH-1:2])
                       & (|(lane_strb[i] & ld_chk_strb));
  end

  assign ld_chk_hit = |overlap;

  assign m_mem_req_addr = lane_addr[rd_idx];
  assign m_mem_req_data = lane_data[rd_idx];
  assign m_mem_req_strb = lane_strb[rd_idx];
  assign m_mem_req_lsid = entries[rd_idx].pld.lsid;

  a_no_write_when_full : assert property (
    @(posedge clk) disable iff (!rst_n) !(s_store_vld && full));

  a_commit_has_entry : assert property (
    @(posedge clk) disable iff (!rst_n) !(commit_vld && (cmt_ptr == wr_ptr)));

endmodule

// File: tb/tb_toy_store_buffer.sv
// Directed bench for toy_store_buffer: one task per scenario, inline checks
// against hand-computed values, single summary line at the end.
module tb_toy_store_buffer;
  import toy_store_buffer_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  s_store_vld;
  stu_pkg                s_store_pld;
  logic                  s_store_rdy;
  logic                  commit_vld;
  logic                  flush;
  logic                  m_mem_req_vld;
  logic                  m_mem_req_rdy;
  logic [ADDR_WIDTH-1:0] m_mem_req_addr;
  logic [DATA_WIDTH-1:0] m_mem_req_data;
  logic [STRB_WIDTH-1:0] m_mem_req_strb;
  logic [LSID_WIDTH-1:0] m_mem_req_lsid;
  logic [ADDR_WIDTH-1:0] ld_chk_addr;
  logic [STRB_WIDTH-1:0] ld_chk_strb;
  logic                  ld_chk_hit;
  logic                  sb_empty;

  int vectors     = 0;
  int miscompares = 0;

  toy_store_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_store_vld    (s_store_vld),
    .s_store_pld    (s_store_pld),
    .s_store_rdy    (s_store_rdy),
    .commit_vld     (commit_vld),
    .flush          (flush),
    .m_mem_req_vld  (m_mem_req_vld),
    .m_mem_req_rdy  (m_mem_req_rdy),
    .m_mem_req_addr (m_mem_req_addr),
    .m_mem_req_data (m_mem_req_data),
    .m_mem_req_strb (m_mem_req_strb),
    .m_mem_req_lsid (m_mem_req_lsid),
    .ld_chk_addr    (ld_chk_addr),
    .ld_chk_strb    (ld_chk_strb),
    .ld_chk_hit     (ld_chk_hit),
    .sb_empty       (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic stu_pkg mk(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [3:0] id);
    stu_pkg p;
    p         = '0;
    p.addr    = a;
    p.data    = d;
    p.strb    = s;
    p.inst_pc = 32'h8000_0000 | a;
    p.lsid    = id;
    return p;
  endfunction

  task automatic push(input stu_pkg p);
    s_store_vld = 1'b1;
    s_store_pld = p;
    tick();
    s_store_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_store_vld = 1'b0; s_store_pld = '0; commit_vld = 1'b0;
    flush = 1'b0; m_mem_req_rdy = 1'b0; ld_chk_addr = '0; ld_chk_strb = 4'hF;
    #12;
    vectors++; if (s_store_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy got %b exp 1", s_store_rdy); end
    vectors++; if (m_mem_req_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld got %b exp 0", m_mem_req_vld); end
    vectors++; if (ld_chk_hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit got %b exp 0", ld_chk_hit); end
    vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b exp 1", sb_empty); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_align();
    push(mk(32'h1002, 32'h0000_ABCD, 4'h3, 4'd1));
    vectors++; if (m_mem_req_vld !== 1'b0) begin miscompares++; $display("FAIL t1_vld_precommit got %b exp 0", m_mem_req_vld); end
    vectors++; if (sb_empty !== 1'b0) begin miscompares++; $display("FAIL t1_empty got %b exp 0", sb_empty); end
    commit_vld = 1'b1; m_mem_req_rdy = 1'b1;
    tick();
    commit_vld = 1'b0;
    vectors++; if (m_mem_req_vld !== 1'b1) begin miscompares++; $display("FAIL t1_vld got %b exp 1", m_mem_req_vld); end
    vectors++; if (m_mem_req_addr !== 32'h1000) begin miscompares++; $display("FAIL t1_addr got %h exp %h", m_mem_req_addr, 32'h1000); end
    vectors++; if (m_mem_req_data !== 32'hABCD_0000) begin miscompares++; $display("FAIL t1_data got %h exp %h", m_mem_req_data, 32'hABCD_0000); end
    vectors++; if (m_mem_req_strb !== 4'hC) begin miscompares++; $display("FAIL t1_strb got %h exp c", m_mem_req_strb); end
    vectors++; if (m_mem_req_lsid !== 4'd1) begin miscompares++; $display("FAIL t1_lsid got %0d exp 1", m_mem_req_lsid); end
    tick();
    m_mem_req_rdy = 1'b0;
    vectors++; if (sb_empty !== 1'b1 || m_mem_req_vld !== 1'b0) begin miscompares++; $display("FAIL t1_drained empty %b vld %b exp 1 0", sb_empty, m_mem_req_vld); end
  endtask

  task automatic test_full_order();
    for (int i = 0; i < 8; i++) begin
      push(mk(32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF, 4'(i)));
      vectors++;
      if (s_store_rdy !== (i < 7)) begin miscompares++; $display("FAIL t2_rdy_after_%0d got %b exp %b", i, s_store_rdy, (i < 7)); end
    end
    commit_vld = 1'b1;
    repeat (8) tick();
    commit_vld = 1'b0;
    vectors++; if (s_store_rdy !== 1'b0) begin miscompares++; $display("FAIL t2_rdy_committed got %b exp 0", s_store_rdy); end
    m_mem_req_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (m_mem_req_vld !== 1'b1 || m_mem_req_addr !== 32'h100 + 32'(4*i) ||
          m_mem_req_data !== 32'hC0DE_0000 + 32'(i) || m_mem_req_lsid !== 4'(i)) begin
        miscompares++;
        $display("FAIL t2_drain_%0d got vld %b addr %h data %h lsid %0d exp 1 %h %h %0d", i, m_mem_req_vld,
                 m_mem_req_addr, m_mem_req_data, m_mem_req_lsid, 32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i), i);
      end
      tick();
      if (i == 0) begin
        vectors++; if (s_store_rdy !== 1'b1) begin miscompares++; $display("FAIL t2_rdy_return got %b exp 1", s_store_rdy); end
      end
    end
    m_mem_req_rdy = 1'b0;
    vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL t2_empty got %b exp 1", sb_empty); end
  endtask

  task automatic test_flush();
    int got;
    for (int i = 0; i < 5; i++) push(mk(32'h300 + 32'(4*i), 32'(i), 4'hF, 4'(i)));
    commit_vld = 1'b1;
    repeat (2) tick();
    commit_vld = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if (sb_empty !== 1'b0 || m_mem_req_vld !== 1'b1) begin miscompares++; $display("FAIL t3_post_flush empty %b vld %b exp 0 1", sb_empty, m_mem_req_vld); end
    m_mem_req_rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      if (m_mem_req_vld) begin
        vectors++;
        if (m_mem_req_addr !== 32'h300 + 32'(4*got)) begin miscompares++; $display("FAIL t3_addr_%0d got %h exp %h", got, m_mem_req_addr, 32'h300 + 32'(4*got)); end
        got++;
      end
      tick();
    end
    m_mem_req_rdy = 1'b0;
    vectors++; if (got !== 2) begin miscompares++; $display("FAIL t3_req_count got %0d exp 2", got); end
    vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL t3_empty got %b exp 1", sb_empty); end
  endtask

  task automatic test_back_to_back();
    push(mk(32'h400, 32'hAAAA_0000, 4'hF, 4'd4));
    push(mk(32'h404, 32'hBBBB_0000, 4'hF, 4'd5));
    commit_vld = 1'b1;
    tick();
    vectors++; if (m_mem_req_addr !== 32'h400) begin miscompares++; $display("FAIL t4_head_before got %h exp 400", m_mem_req_addr); end
    s_store_vld = 1'b1; s_store_pld = mk(32'h408, 32'hCCCC_0000, 4'hF, 4'd6);
    flush = 1'b1; m_mem_req_rdy = 1'b1;
    tick();
    s_store_vld = 1'b0; commit_vld = 1'b0; flush = 1'b0; m_mem_req_rdy = 1'b0;
    vectors++; if (m_mem_req_vld !== 1'b1 || m_mem_req_addr !== 32'h404) begin miscompares++; $display("FAIL t4_head_after vld %b addr %h exp 1 404", m_mem_req_vld, m_mem_req_addr); end
    vectors++; if (sb_empty !== 1'b0) begin miscompares++; $display("FAIL t4_not_empty got %b exp 0", sb_empty); end
    m_mem_req_rdy = 1'b1;
    tick();
    m_mem_req_rdy = 1'b0;
    vectors++; if (sb_empty !== 1'b1 || m_mem_req_vld !== 1'b0) begin miscompares++; $display("FAIL t4_write_dropped empty %b vld %b exp 1 0", sb_empty, m_mem_req_vld); end
  endtask

  task automatic test_ld_chk();
    s_store_vld = 1'b1; s_store_pld = mk(32'h2000, 32'h11, 4'h1, 4'd2);
    ld_chk_addr = 32'h2000; ld_chk_strb = 4'h1;
    #1;
    vectors++; if (ld_chk_hit !== 1'b0) begin miscompares++; $display("FAIL t5_same_cycle got %b exp 0", ld_chk_hit); end
    tick();
    s_store_vld = 1'b0;
    push(mk(32'h3001, 32'h22, 4'h1, 4'd3));
    ld_chk_addr = 32'h2000; ld_chk_strb = 4'h1; #1;
    vectors++; if (ld_chk_hit !== 1'b1) begin miscompares++; $display("FAIL t5_2000_1 got %b exp 1", ld_chk_hit); end
    ld_chk_addr = 32'h2001; ld_chk_strb = 4'h2; #1;
    vectors++; if (ld_chk_hit !== 1'b0) begin miscompares++; $display("FAIL t5_2001_2 got %b exp 0", ld_chk_hit); end
    ld_chk_addr = 32'h2004; ld_chk_strb = 4'h1; #1;
    vectors++; if (ld_chk_hit !== 1'b0) begin miscompares++; $display("FAIL t5_2004_1 got %b exp 0", ld_chk_hit); end
    ld_chk_addr = 32'h3000; ld_chk_strb = 4'h2; #1;
    vectors++; if (ld_chk_hit !== 1'b1) begin miscompares++; $display("FAIL t5_3000_2 got %b exp 1", ld_chk_hit); end
    ld_chk_addr = 32'h3000; ld_chk_strb = 4'h1; #1;
    vectors++; if (ld_chk_hit !== 1'b0) begin miscompares++; $display("FAIL t5_3000_1 got %b exp 0", ld_chk_hit); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ld_chk_addr = 32'h2000; ld_chk_strb = 4'h1; #1;
    vectors++; if (sb_empty !== 1'b1 || ld_chk_hit !== 1'b0) begin miscompares++; $display("FAIL t5_flushed empty %b hit %b exp 1 0", sb_empty, ld_chk_hit); end
  endtask

  task automatic test_stall_reset();
    push(mk(32'h5003, 32'h0000_EEFF, 4'h3, 4'd7));
    commit_vld = 1'b1;
    tick();
    commit_vld = 1'b0;
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (m_mem_req_vld !== 1'b1 || m_mem_req_addr !== 32'h5000 ||
          m_mem_req_data !== 32'hFF00_0000 || m_mem_req_strb !== 4'h8) begin
        miscompares++;
        $display("FAIL t6_stall_%0d vld %b addr %h data %h strb %h exp 1 5000 ff000000 8", c,
                 m_mem_req_vld, m_mem_req_addr, m_mem_req_data, m_mem_req_strb);
      end
      tick();
    end
    m_mem_req_rdy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (m_mem_req_vld !== 1'b0) begin miscompares++; $display("FAIL t6_rst_vld got %b exp 0", m_mem_req_vld); end
    vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL t6_rst_empty got %b exp 1", sb_empty); end
    vectors++; if (s_store_rdy !== 1'b1) begin miscompares++; $display("FAIL t6_rst_rdy got %b exp 1", s_store_rdy); end
    m_mem_req_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_align();
    test_full_order();
    test_flush();
    test_back_to_back();
    test_ld_chk();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
